// File: rtl/matrix_mult_scheduler_pkg.sv
// Shared definitions for the matrix multiply scheduler slice.
//   WORD_WIDTH    : width of one matrix element / result word.
//   sched_state_t : scheduler state encoding.
//   addr_width()  : address/counter width helper, never below 1 bit.
package matmul_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_mult_scheduler_if.sv
// Link between the scheduler and one inner_product unit.
//   master : scheduler side (drives operands, strobes, result-ready).
//   slave  : inner_product side (drives operand acks and the result).
//
// Handshake: an operand vector is transferred on the first clock edge where
// its strobe and its ack are both high; the strobe stays high until that edge.
// A result is transferred on the edge where ip_out_stb and ip_out_ack are both
// high; ip_out_stb is a single-cycle pulse and ip_out is valid only with it.
interface matrix_mult_scheduler_if #(parameter int N = 4);
    import matmul_pkg::*;

    logic [WORD_WIDTH*N-1:0] ip_row;
    logic [WORD_WIDTH*N-1:0] ip_column;
    logic                    ip_row_stb;
    logic                    ip_column_stb;
    logic                    ip_out_ack;
    logic                    ip_row_ack;
    logic                    ip_column_ack;
    logic [WORD_WIDTH-1:0]   ip_out;
    logic                    ip_out_stb;

    modport master (
        output ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
        input  ip_row_ack, ip_column_ack, ip_out, ip_out_stb
    );

    modport slave (
        input  ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
        output ip_row_ack, ip_column_ack, ip_out, ip_out_stb
    );

endinterface

// File: rtl/matrix_mult_scheduler_operand_mux.sv
// Combinational operand selection for one output element C(i,j).
//   a_mat, b_mat : flattened row-major N x N matrices.
//   row_sel      : row index i into A.
//   col_sel      : column index j into B.
//   row          : A(i,k) at element k.
//   column       : B(k,j) at element k.
module matrix_operand_mux
    import matmul_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 1
) (
    input  logic [WORD_WIDTH*N*N-1:0] a_mat,
    input  logic [WORD_WIDTH*N*N-1:0] b_mat,
    input  logic [CW-1:0]             row_sel,
    input  logic [CW-1:0]             col_sel,
    output logic [WORD_WIDTH*N-1:0]   row,
    output logic [WORD_WIDTH*N-1:0]   column
);

    // Compare against every index instead of multiplying a variable into a
    // part-select base; keeps each slice constant.
    always_comb begin
        row    = '0;
        column = '0;
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < N; r++) begin
                if (row_sel == CW'(r))
                    row[WORD_WIDTH*k +: WORD_WIDTH] = a_mat[WORD_WIDTH*(r*N+k) +: WORD_WIDTH];
                if (col_sel == CW'(r))
                    column[WORD_WIDTH*k +: WORD_WIDTH] = b_mat[WORD_WIDTH*(k*N+r) +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/matrix_mult_scheduler.sv
// Walks one shared inner_product unit over all N x N elements of C = A*B,
// writing each result to a result-memory port.
//   clk, rst           : clock, asynchronous active-high reset.
//   start              : begin a product (accepted in IDLE only).
//   a_mat, b_mat       : operand matrices, stable while busy.
//   busy, done, error  : status; done is a one-cycle pulse, error is sticky
//                        (watchdog abort) until the next accepted start.
//   res_we/addr/data   : one write per element, addr = i*N + j.
//   dbg_state          : current scheduler state.
//   ip                 : handshake link to the inner_product unit.
module matrix_mult_scheduler
    import matmul_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WORD_WIDTH*N*N-1:0]       a_mat,
    input  logic [WORD_WIDTH*N*N-1:0]       b_mat,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            res_we,
    output logic [addr_width(N*N)-1:0]      res_addr,
    output logic [WORD_WIDTH-1:0]           res_data,
    output sched_state_t                    dbg_state,
    matrix_mult_scheduler_if.master         ip
);

    localparam int CW   = addr_width(N);
    localparam int AW   = addr_width(N*N);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   IDX_LAST = CW'(N - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    sched_state_t              state, state_nxt;
    logic [CW-1:0]             i, j, i_nxt, j_nxt;
    logic                      row_flag, col_flag;
    logic                      row_seen, col_seen;
    logic [WD_W-1:0]           wd_cnt;
    logic                      wd_expired;
    logic [WORD_WIDTH*N-1:0]   mux_row, mux_col;

    // Operands are selected with the *next* indices so the vector registers
    // hold the right row/column from the first ISSUE cycle onward.
    matrix_operand_mux #(.N(N), .CW(CW)) u_mux (
        .a_mat   (a_mat),
        .b_mat   (b_mat),
        .row_sel (i_nxt),
        .col_sel (j_nxt),
        .row     (mux_row),
        .column  (mux_col)
    );

    assign dbg_state  = state;
    assign res_addr   = AW'(i) * AW'(N) + AW'(j);
    assign row_seen   = row_flag | ip.ip_row_ack;
    assign col_seen   = col_flag | ip.ip_column_ack;
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt        = state;
        i_nxt            = i;
        j_nxt            = j;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        res_we           = (state == S_WRITE);
        ip.ip_row_stb    = (state == S_ISSUE);
        ip.ip_column_stb = (state == S_ISSUE);
        ip.ip_out_ack    = (state == S_ISSUE) || (state == S_WAIT);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            S_ISSUE: begin
                if (row_seen && col_seen) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final watchdog cycle still wins.
                if (ip.ip_out_stb)   state_nxt = S_WRITE;
                else if (wd_expired) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                if (j == IDX_LAST) begin
                    j_nxt = '0;
                    if (i == IDX_LAST) begin
                        i_nxt     = '0;
                        state_nxt = S_DONE;
                    end else begin
                        i_nxt     = i + 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else begin
                    j_nxt     = j + 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            i            <= '0;
            j            <= '0;
            row_flag     <= 1'b0;
            col_flag     <= 1'b0;
            wd_cnt       <= '0;
            error        <= 1'b0;
            res_data     <= '0;
            ip.ip_row    <= '0;
            ip.ip_column <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;

            if (state == S_IDLE && start)
                error <= 1'b0;
            else if (state == S_WAIT && !ip.ip_out_stb && wd_expired)
                error <= 1'b1;

            // Acks may land in different cycles; remember each until both seen.
            if (state == S_ISSUE && !(row_seen && col_seen)) begin
                row_flag <= row_seen;
                col_flag <= col_seen;
            end else begin
                row_flag <= 1'b0;
                col_flag <= 1'b0;
            end

            // Any non-WAIT state zeroes the watchdog, so it restarts on entry.
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;

            if (state == S_WAIT && ip.ip_out_stb)
                res_data <= ip.ip_out;

            if (state_nxt == S_ISSUE && state != S_ISSUE) begin
                ip.ip_row    <= mux_row;
                ip.ip_column <= mux_col;
            end
        end
    end

endmodule
